// File: rtl/toll_booth_ctrl.sv
// Single-lane toll booth controller: synchronises coin sensors, accumulates credit, drives go/stop lamps.
// Optional macro PASS_COUNT_EN adds a 16-bit PassCount output counting STOP->GO transitions.
module toll_booth_ctrl #(
   parameter int TOLL_CENTS = 25,
   parameter int GO_CYCLES  = 8,
   parameter int CREDIT_W   = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Nickel1,
   input  logic        Nickel2,
   input  logic        Dime,
   input  logic        Quarter,
   output logic        LEDgo,
   output logic        LEDstop
`ifdef PASS_COUNT_EN
   ,
   output logic [15:0] PassCount
`endif
);

   typedef enum logic {STOP, GO} state_t;

   localparam int                  TIMER_W    = (GO_CYCLES > 1) ? $clog2(GO_CYCLES) : 1;
   localparam logic [CREDIT_W-1:0] TOLL       = CREDIT_W'(TOLL_CENTS);
   localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(GO_CYCLES - 1);

   logic [3:0]          sensors;
   logic [3:0]          s1, s2, h;
   logic [1:0]          warm;
   logic [3:0]          pulse;
   logic [CREDIT_W-1:0] add;
   logic [CREDIT_W-1:0] credit;
   logic [TIMER_W-1:0]  timer;
   state_t              state;

   assign sensors = {Quarter, Dime, Nickel2, Nickel1};
   assign pulse   = s2 & ~h;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      add = '0;
      if (pulse[0]) add = add + CREDIT_W'(5);
      if (pulse[1]) add = add + CREDIT_W'(5);
      if (pulse[2]) add = add + CREDIT_W'(10);
      if (pulse[3]) add = add + CREDIT_W'(25);
   end

   // History holds at 1 until the synchroniser has carried two real samples, so a sensor
   // already high at reset release never looks like a fresh rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= '0;
         s2   <= '0;
         h    <= '1;
         warm <= '0;
      end else begin
         s1   <= sensors;
         s2   <= s1;
         warm <= {warm[0], 1'b1};
         h    <= warm[1] ? s2 : '1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= STOP;
         credit    <= '0;
         timer     <= '0;
         LEDgo     <= 1'b0;
         LEDstop   <= 1'b1;
`ifdef PASS_COUNT_EN
         PassCount <= '0;
`endif
      end else begin
         case (state)
            STOP: begin
               if (credit >= TOLL) begin
                  state     <= GO;
                  credit    <= credit - TOLL + add;
                  timer     <= TIMER_LOAD;
                  LEDgo     <= 1'b1;
                  LEDstop   <= 1'b0;
`ifdef PASS_COUNT_EN
                  PassCount <= PassCount + 16'd1;
`endif
               end else begin
                  credit <= credit + add;
               end
            end
            GO: begin
               credit <= credit + add;
               if (timer == '0) begin
                  state   <= STOP;
                  LEDgo   <= 1'b0;
                  LEDstop <= 1'b1;
               end else begin
                  timer <= timer - TIMER_W'(1);
               end
            end
            default: begin
               state   <= STOP;
               LEDgo   <= 1'b0;
               LEDstop <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_toll_booth_ctrl.sv
// Scoreboard bench for toll_booth_ctrl: a passage-schedule model predicts each GO start cycle,
// a monitor pops predictions as the green lamp rises and checks window length and lamp complement.
module tb_toll_booth_ctrl;

   localparam int TOLL = 25;
   localparam int GO   = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic Nickel1 = 1'b0, Nickel2 = 1'b0, Dime = 1'b0, Quarter = 1'b0;
   logic LEDgo, LEDstop;
`ifdef PASS_COUNT_EN
   logic [15:0] PassCount;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   bit prev_go = 1'b0;
   int run_len = 0;
   int popped;
   int seen_passes = 0;

   int exp_q[$];
   int model_total, model_passes, model_last;
   logic [3:0] sq[$];

   toll_booth_ctrl #(.TOLL_CENTS(TOLL), .GO_CYCLES(GO), .CREDIT_W(7)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Nickel1  (Nickel1),
      .Nickel2  (Nickel2),
      .Dime     (Dime),
      .Quarter  (Quarter),
      .LEDgo    (LEDgo),
      .LEDstop  (LEDstop)
`ifdef PASS_COUNT_EN
      ,
      .PassCount(PassCount)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input integer act, input integer exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int coin_value(input logic [3:0] m);
      return (m[0] ? 5 : 0) + (m[1] ? 5 : 0) + (m[2] ? 10 : 0) + (m[3] ? 25 : 0);
   endfunction

   task automatic model_reset();
      model_total  = 0;
      model_passes = 0;
      model_last   = -1000;
      seen_passes  = 0;
      exp_q.delete();
   endtask

   // Passage k opens one cycle after cumulative credit first covers k tolls, but no earlier than
   // one STOP cycle after the previous green window of GO cycles.
   task automatic model_coins(input int t_credit, input int value);
      model_total += value;
      while (model_total >= (model_passes + 1) * TOLL) begin
         int s;
         s = (t_credit + 1 > model_last + GO + 1) ? t_credit + 1 : model_last + GO + 1;
         exp_q.push_back(s);
         model_last = s;
         model_passes++;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("lamp_complement", LEDstop, !LEDgo);
         if (LEDgo && !prev_go) begin
            seen_passes++;
            if (exp_q.size() == 0) begin
               check("unexpected_go", cyc, -1);
            end else begin
               popped = exp_q.pop_front();
               check("go_start_cycle", cyc, popped);
            end
`ifdef PASS_COUNT_EN
            check("pass_count", PassCount, seen_passes);
`endif
            run_len = 0;
         end
         if (LEDgo) run_len++;
         if (!LEDgo && prev_go) check("go_length", run_len, GO);
         prev_go = LEDgo;
      end else begin
         prev_go = 1'b0;
         run_len = 0;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Each scheduled rise holds its sensor high for two cycles; the credit lands three edges later.
   task automatic play();
      logic [3:0] prev;
      logic [3:0] cur;
      prev = '0;
      for (int i = 0; i < sq.size() + 2; i++) begin
         cur = (i < sq.size()) ? sq[i] : 4'b0000;
         @(negedge clk);
         {Quarter, Dime, Nickel2, Nickel1} = cur | prev;
         if (cur != 4'b0000) model_coins(cyc + 3, coin_value(cur));
         prev = cur;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || LEDgo === 1'b1) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check("drain_timeout", exp_q.size(), 0);
      idle(2);
   endtask

   task automatic apply_reset(input logic q_hold);
      @(negedge clk);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      {Quarter, Dime, Nickel2, Nickel1} = {q_hold, 3'b000};
      #1;
      check("reset_ledgo", LEDgo, 0);
      check("reset_ledstop", LEDstop, 1);
      idle(3);
      model_reset();
      rst_n = 1'b1;
      idle(4);
      mon_en = 1'b1;
   endtask

   task automatic gen_random(input int len);
      int last[4];
      int budget;
      logic [3:0] m;
      last   = '{-10, -10, -10, -10};
      budget = 0;
      sq.delete();
      for (int i = 0; i < len; i++) begin
         m = '0;
         for (int b = 0; b < 4; b++) begin
            if (i - last[b] >= 4 && $urandom_range(0, 5) == 0 && budget + 25 <= 95) begin
               m[b] = 1'b1;
               last[b] = i;
               budget += coin_value(4'b0001 << b);
            end
         end
         sq.push_back(m);
      end
   endtask

   initial begin
      int n;
      apply_reset(1'b0);
      idle(20);

      sq = '{4'b1000};
      play(); drain();

      sq = '{4'b0001, 0, 0, 0, 4'b0010, 0, 0, 0, 4'b0100};
      play(); idle(20);
      sq = '{4'b0001};
      play(); drain();

      sq = '{4'b1100};
      play(); drain();
      sq = '{4'b0101};
      play(); drain();

      sq = '{4'b1000, 0, 0, 0, 4'b1000, 0, 0, 0, 4'b1000};
      play(); drain();

      apply_reset(1'b1);
      idle(10);
      sq = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
      play(); drain();

      sq = '{4'b1000, 0, 0, 0, 4'b0100};
      play();
      n = 0;
      while (LEDgo !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("midgo_wait_timeout", LEDgo, 1);
      idle(1);
      apply_reset(1'b0);
      idle(10);
      sq = '{4'b0101};
      play(); idle(20);

      for (int r = 0; r < 8; r++) begin
         gen_random(40);
         play(); drain();
      end

      idle(GO + 4);
      check("queue_empty_end", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
